// File: rtl/switch_debouncer.sv
// Debouncer for 10 slide switches and 2 active-low push-buttons: per-input
// two-flop synchronizer, 20-bit stability counter, edge pulses and switch decode.
module switch_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] SW,
    input  logic       viewKey,
    input  logic       clearKey,
    output logic [9:0] swClean,
    output logic [9:0] swRise,
    output logic [9:0] swFall,
    output logic [3:0] swCount,
    output logic       swOneHot,
    output logic [3:0] swIndex,
    output logic       viewBestTime,
    output logic       clearBest,
    output logic       clearPress
);

    localparam int          NUM_IN    = 12;
    // Switches idle low, keys idle high (released).
    localparam logic [11:0] RESET_VAL = 12'hC00;
    localparam logic [19:0] LAST_CNT  = 20'(DEBOUNCE_CYCLES - 1);

    logic [NUM_IN-1:0] raw;
    logic [NUM_IN-1:0] clean_vec;
    logic [NUM_IN-1:0] prev_vec;

    assign raw = {clearKey, viewKey, SW};

    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_chan
            logic        sync1_reg;
            logic        sync2_reg;
            logic        clean_reg;
            logic        prev_reg;
            logic [19:0] cnt_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sync1_reg <= RESET_VAL[gi];
                    sync2_reg <= RESET_VAL[gi];
                    clean_reg <= RESET_VAL[gi];
                    prev_reg  <= RESET_VAL[gi];
                    cnt_reg   <= 20'd0;
                end else begin
                    sync1_reg <= raw[gi];
                    sync2_reg <= sync1_reg;
                    prev_reg  <= clean_reg;
                    // Any cycle matching the accepted level restarts the stability window.
                    if (sync2_reg == clean_reg) begin
                        cnt_reg <= 20'd0;
                    end else if (cnt_reg == LAST_CNT) begin
                        clean_reg <= sync2_reg;
                        cnt_reg   <= 20'd0;
                    end else begin
                        cnt_reg <= cnt_reg + 20'd1;
                    end
                end
            end

            assign clean_vec[gi] = clean_reg;
            assign prev_vec[gi]  = prev_reg;
        end
    endgenerate

    assign swClean      = clean_vec[9:0];
    assign swRise       = clean_vec[9:0] & ~prev_vec[9:0];
    assign swFall       = ~clean_vec[9:0] & prev_vec[9:0];
    assign viewBestTime = clean_vec[10];
    assign clearBest    = clean_vec[11];
    assign clearPress   = prev_vec[11] & ~clean_vec[11];

    logic [3:0] count_next;
    logic [3:0] index_next;

    always_comb begin
        count_next = 4'd0;
        for (int i = 0; i < 10; i++) begin
            count_next = count_next + {3'b000, swClean[i]};
        end
    end

    assign swOneHot = (count_next == 4'd1);

    always_comb begin
        index_next = 4'd15;
        if (swOneHot) begin
            for (int i = 0; i < 10; i++) begin
                if (swClean[i]) begin
                    index_next = 4'(i);
                end
            end
        end
    end

    assign swCount = count_next;
    assign swIndex = index_next;

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer (DEBOUNCE_CYCLES = 4): directed
// scenarios plus random bouncing, checked every cycle against a window model.
module tb_switch_debouncer;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] SW = 10'h000;
    logic       viewKey = 1'b1;
    logic       clearKey = 1'b1;
    logic [9:0] swClean, swRise, swFall;
    logic [3:0] swCount, swIndex;
    logic       swOneHot, viewBestTime, clearBest, clearPress;

    switch_debouncer #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .reset(reset), .SW(SW), .viewKey(viewKey), .clearKey(clearKey),
        .swClean(swClean), .swRise(swRise), .swFall(swFall), .swCount(swCount),
        .swOneHot(swOneHot), .swIndex(swIndex), .viewBestTime(viewBestTime),
        .clearBest(clearBest), .clearPress(clearPress)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // hist[k] holds the raw inputs sampled at edge k+1 after reset release.
    logic [11:0] hist[$];
    logic [11:0] m_clean;
    logic [11:0] m_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_clean = 12'hC00;
        m_prev  = 12'hC00;
    endtask

    // A new level is accepted at edge t when the D samples taken at edges
    // t-D-1 .. t-2 all disagree with the accepted level.
    task automatic model_edge(input logic [11:0] sample);
        int  t;
        bit  all_diff;
        hist.push_back(sample);
        t = hist.size();
        m_prev = m_clean;
        if (t - D - 1 >= 1) begin
            for (int b = 0; b < 12; b++) begin
                all_diff = 1'b1;
                for (int e = t - D - 1; e <= t - 2; e++) begin
                    if (hist[e-1][b] == m_prev[b]) all_diff = 1'b0;
                end
                if (all_diff) m_clean[b] = ~m_prev[b];
            end
        end
    endtask

    task automatic check_model();
        logic [9:0] c;
        int         n;
        logic [3:0] idx;
        c   = m_clean[9:0];
        n   = $countones(c);
        idx = 4'd15;
        if (n == 1) begin
            for (int i = 0; i < 10; i++) if (c[i]) idx = 4'(i);
        end
        chk("swClean", 32'(swClean), 32'(c));
        chk("swRise", 32'(swRise), 32'(c & ~m_prev[9:0]));
        chk("swFall", 32'(swFall), 32'(~c & m_prev[9:0]));
        chk("swCount", 32'(swCount), 32'(n));
        chk("swOneHot", 32'(swOneHot), 32'(n == 1));
        chk("swIndex", 32'(swIndex), 32'(idx));
        chk("viewBestTime", 32'(viewBestTime), 32'(m_clean[10]));
        chk("clearBest", 32'(clearBest), 32'(m_clean[11]));
        chk("clearPress", 32'(clearPress), 32'(m_prev[11] & ~m_clean[11]));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge({clearKey, viewKey, SW});
            @(negedge clk);
            check_model();
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_swClean"}, 32'(swClean), 32'h000);
        chk({tag, "_swRise"}, 32'(swRise), 32'h000);
        chk({tag, "_swFall"}, 32'(swFall), 32'h000);
        chk({tag, "_swCount"}, 32'(swCount), 32'h0);
        chk({tag, "_swOneHot"}, 32'(swOneHot), 32'h0);
        chk({tag, "_swIndex"}, 32'(swIndex), 32'hF);
        chk({tag, "_viewBestTime"}, 32'(viewBestTime), 32'h1);
        chk({tag, "_clearBest"}, 32'(clearBest), 32'h1);
        chk({tag, "_clearPress"}, 32'(clearPress), 32'h0);
    endtask

    // Assert reset between clock edges, hold a few cycles, release on a falling edge.
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check_reset_vals({tag, "_async"});
        repeat (3) @(negedge clk);
        check_reset_vals({tag, "_held"});
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [11:0] r;
        model_reset();
        #7 check_reset_vals("por");
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Single switch rise: accepted at edge D+2 with one pulse.
        SW = 10'h008;
        run(5);
        chk("req029_pre", 32'(swClean), 32'h000);
        run(1);
        chk("req029_clean", 32'(swClean), 32'h008);
        chk("req029_rise", 32'(swRise), 32'h008);
        chk("req029_index", 32'(swIndex), 32'd3);
        chk("req029_count", 32'(swCount), 32'd1);
        run(1);
        chk("req029_rise_once", 32'(swRise), 32'h000);
        $display("step single_rise done checks=%0d", checks);

        SW = 10'h000;
        run(8);
        // Short bounce on SW[5] must never be accepted.
        SW[5] = 1'b1; run(2);
        SW[5] = 1'b0; run(2);
        SW[5] = 1'b1; run(2);
        SW[5] = 1'b0; run(8);
        chk("req030_clean", 32'(swClean[5]), 32'h0);
        $display("step bounce done checks=%0d", checks);

        SW = 10'h084;
        run(6);
        chk("req031_rise", 32'(swRise), 32'h084);
        chk("req031_count", 32'(swCount), 32'd2);
        chk("req031_index", 32'(swIndex), 32'd15);
        $display("step dual_rise done checks=%0d", checks);

        clearKey = 1'b0;
        run(6);
        chk("req032_clearBest", 32'(clearBest), 32'h0);
        chk("req032_press", 32'(clearPress), 32'h1);
        run(4);
        clearKey = 1'b1;
        run(6);
        chk("req032_release", 32'(clearBest), 32'h1);
        $display("step clear_key done checks=%0d", checks);

        SW = 10'h3FF;
        run(8);
        chk("req034_count", 32'(swCount), 32'd10);
        chk("req034_index", 32'(swIndex), 32'd15);
        $display("step all_high done checks=%0d", checks);

        // Reset mid-count on SW[0], then re-debounce from release.
        SW = 10'h000;
        pulse_reset("rst1");
        run(8);
        SW[0] = 1'b1;
        run(3);
        pulse_reset("req033");
        run(5);
        chk("req033_pre", 32'(swClean[0]), 32'h0);
        run(1);
        chk("req033_clean", 32'(swClean[0]), 32'h1);
        chk("req033_rise", 32'(swRise[0]), 32'h1);
        run(1);
        chk("req033_rise_once", 32'(swRise[0]), 32'h0);
        $display("step reset_mid_count done checks=%0d", checks);

        // Random bouncing on all 12 inputs.
        for (int c = 0; c < 400; c++) begin
            r = {clearKey, viewKey, SW};
            for (int b = 0; b < 12; b++) begin
                if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            end
            {clearKey, viewKey, SW} = r;
            run(1);
        end
        $display("step random done checks=%0d", checks);

        // Raw inputs differing from reset values at release: no pulse on first cycle.
        SW = 10'h155; viewKey = 1'b0; clearKey = 1'b0;
        pulse_reset("rst2");
        run(1);
        chk("req028_rise", 32'(swRise), 32'h000);
        chk("req028_press", 32'(clearPress), 32'h0);
        run(10);
        $display("step release_mismatch done checks=%0d", checks);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
